io_bus_ctrl: RTL
================

Name: io_bus_ctrl

Overview:
Parametrised successor to the fixed address decoder and read-data mux around the cpu_65c02 core. Holds the IO bank registers (0x0000/0x0001) and the ROM overlay register (0x0002). Decodes RAM, ROM and an N-channel IO page. Adds what the fixed decoder lacks: per-channel wait states on RDY, one-cycle read/write strobes, and defined behaviour for unmapped banks.

Parameters:
NUM_CH, 8, number of IO channels selectable through the bank register (1..16).
WAIT_W, 3, width of each channel's wait-state count.
IO_PAGE, 8'hFE, high address byte of the IO page.
ROM_BASE, 8'hE0, high address byte where the switchable ROM window begins.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  synchronous, active-high reset.
addr_i  in  16  CPU address bus (AB).
we_i  in  1  CPU write enable.
data_i  in  8  CPU write data (DO).
data_o  out  8  read data to CPU DI, valid the cycle after the committed access.
rdy_o  out  1  CPU RDY; low stalls the core.
ram_cs_o  out  1  RAM select, combinational.
rom_cs_o  out  1  ROM select, combinational.
ram_data_i  in  8  RAM read data.
rom_data_i  in  8  ROM read data.
ch_cs_o  out  NUM_CH  one-hot IO channel select, combinational.
ch_rd_o  out  1  one-cycle read strobe at commit.
ch_wr_o  out  1  one-cycle write strobe at commit.
reg_addr_o  out  8  addr_i[7:0] passed through to channels.
ch_data_i  in  NUM_CH*8  concatenated channel read data; channel k occupies [8k+7:8k].
ch_wait_i  in  NUM_CH*WAIT_W  per-channel wait-state counts.
bank_o  out  16  current IO bank register.
rom_en_o  out  1  1 = ROM is mapped at ROM_BASE..0xFDFF.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - bank=0x0000, romctl=0x00 (so rom_en_o=1).
  - FSM=IDLE, wait counter=0, rdy_o=1, no strobes.
  - The sampled select is cleared, so data_o reads 0xFF.
  - This applies mid-wait as well; the pending access is abandoned with no strobe.
- Decode priority, highest first:
  - 0x0000/0x0001/0x0002: internal registers.
  - 0xFF00-0xFFFF: ROM, always.
  - IO_PAGE page: IO.
  - ROM_BASE..0xFDFF: ROM if rom_en_o=1, else RAM.
  - Everything else: RAM.
  - RAM is shadowed at 0x0000-0x0002.
- IO channel is bank_o. If bank_o >= NUM_CH, the IO page is unmapped:
  - ch_cs_o all zero, no wait;
  - reads return 0xFF;
  - writes are dropped silently.
- Register writes take effect at the clock edge of the write cycle:
  - 0x0000 writes bank[7:0];
  - 0x0001 writes bank[15:8];
  - 0x0002 writes romctl, where bit0=0 means ROM and bit0=1 means RAM;
  - rom_en_o = ~romctl[0].
  - An access in the very next cycle uses the new value.
- Register reads return bank[7:0], bank[15:8] and romctl respectively.
- FSM states are IDLE and WAIT.
  - IDLE, IO access to channel k with W=ch_wait_i[k]:
    - W=0: commit this cycle, rdy_o=1.
    - W>0: rdy_o=0 combinationally, counter<=W-1, go to WAIT.
  - WAIT:
    - rdy_o=0 while counter>0, decrementing each cycle.
    - When counter=0: rdy_o=1, commit, return to IDLE.
    - Total stall is exactly W cycles.
  - The CPU holds addr_i/we_i/data_i while rdy_o=0. W is sampled on entry to WAIT; changes to ch_wait_i mid-wait are ignored.
- Commit cycle:
  - ch_rd_o=~we_i, ch_wr_o=we_i, each high for exactly one cycle.
  - Strobes are never asserted for non-IO or unmapped accesses.
- Read data path:
  - Source select is registered at every cycle where rdy_o=1.
  - data_o in cycle T+1 comes from the source sampled in commit cycle T: RAM, ROM, register, channel, or 0xFF when unmapped.
- Back-to-back waited IO accesses each incur their full W. Returning to IDLE re-evaluates the new address.

Decomposition:
- Package io_bus_pkg holds:
  - register addresses 0x0000/0x0001/0x0002;
  - IO_PAGE and ROM_BASE defaults;
  - the FSM state enum;
  - the read-source enum (RAM, ROM, REG, CH, NONE).
- One sub-module, io_wait_ctrl: the FSM plus wait counter, producing rdy_o and the commit pulse.
- Decode logic and the data mux stay in io_bus_ctrl.

Test Plan:
- Reset, then read 0x0002 -> data_o=0x00, rom_en_o=1. Read 0xE123 -> rom_cs_o=1, data_o=rom_data_i in the next cycle.
- Write 0x01 to 0x0002, then read 0xE123 the next cycle -> ram_cs_o=1, rom_cs_o=0. Read 0xFFFC -> rom_cs_o=1.
- Write bank=0x0003 with ch_wait_i[3]=0, then read 0xFE05 -> ch_cs_o=8'b00001000, reg_addr_o=0x05, ch_rd_o pulse 1 cycle, rdy_o stays 1, data_o=ch_data_i[31:24] in the next cycle.
- bank=2 with wait=3, write 0xA5 to 0xFE10 -> rdy_o low 3 cycles, then ch_wr_o a single pulse with data_i=0xA5. Second back-to-back access -> another 3-cycle stall.
- bank=0x0009 with NUM_CH=8, read 0xFE00 -> data_o=0xFF, no strobe, rdy_o=1. Write -> bank_o/romctl and all channels unchanged.
- rst_i asserted during the 2nd wait cycle -> next cycle rdy_o=1, no strobe, bank_o=0, rom_en_o=1.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared constants and enums for the 65C02 IO bus controller.
package io_bus_pkg;

  localparam logic [15:0] REG_BANK_LO = 16'h0000;
  localparam logic [15:0] REG_BANK_HI = 16'h0001;
  localparam logic [15:0] REG_ROMCTL  = 16'h0002;

  localparam logic [7:0] IO_PAGE_DEF  = 8'hFE;
  localparam logic [7:0] ROM_BASE_DEF = 8'hE0;
  localparam logic [7:0] ROM_TOP_HI   = 8'hFD;
  localparam logic [7:0] VEC_PAGE     = 8'hFF;
  localparam logic [7:0] OPEN_BUS     = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } wstate_e;

  typedef enum logic [2:0] {
    SRC_RAM,
    SRC_ROM,
    SRC_REG,
    SRC_CH,
    SRC_NONE
  } src_e;

endpackage

// File: rtl/io_wait_ctrl.sv
// Wait-state sequencer: stalls RDY for W cycles, then emits a commit pulse.
import io_bus_pkg::*;

module io_wait_ctrl #(
  parameter int WAIT_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [WAIT_W-1:0] wait_i,
  output logic              rdy_o,
  output logic              commit_o
);

  localparam logic [WAIT_W-1:0] CNT_ZERO = '0;
  localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

  wstate_e           state_q;
  logic [WAIT_W-1:0] cnt_q;

  always_comb begin
    rdy_o    = 1'b1;
    commit_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_o    = ~req_i | (wait_i == CNT_ZERO);
        commit_o = req_i & (wait_i == CNT_ZERO);
      end
      ST_WAIT: begin
        rdy_o    = (cnt_q == CNT_ZERO);
        commit_o = (cnt_q == CNT_ZERO);
      end
      default: begin
        rdy_o    = 1'b1;
        commit_o = 1'b0;
      end
    endcase
  end

  // W is latched into the counter on entry; later wait_i changes are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i && (wait_i != CNT_ZERO)) begin
            state_q <= ST_WAIT;
            cnt_q   <= wait_i - CNT_ONE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_ZERO) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Address decoder, bank/ROM-overlay registers and read-data mux
// for the 65C02 system bus.
import io_bus_pkg::*;

module io_bus_ctrl #(
  parameter int          NUM_CH   = 8,
  parameter int          WAIT_W   = 3,
  parameter logic [7:0]  IO_PAGE  = IO_PAGE_DEF,
  parameter logic [7:0]  ROM_BASE = ROM_BASE_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [15:0]              addr_i,
  input  logic                     we_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic                     rdy_o,
  output logic                     ram_cs_o,
  output logic                     rom_cs_o,
  input  logic [7:0]               ram_data_i,
  input  logic [7:0]               rom_data_i,
  output logic [NUM_CH-1:0]        ch_cs_o,
  output logic                     ch_rd_o,
  output logic                     ch_wr_o,
  output logic [7:0]               reg_addr_o,
  input  logic [NUM_CH*8-1:0]      ch_data_i,
  input  logic [NUM_CH*WAIT_W-1:0] ch_wait_i,
  output logic [15:0]              bank_o,
  output logic                     rom_en_o
);

  logic [15:0] bank_q;
  logic [7:0]  romctl_q;
  src_e        src_q, src_d;
  logic [3:0]  chsel_q;
  logic [7:0]  regval_q, regval_d;

  logic [7:0]        hi;
  logic              is_reg, is_io, in_win, bank_ok, io_map;
  logic              sel_ram, sel_rom;
  logic [WAIT_W-1:0] wait_sel;
  logic [7:0]        ch_rd_data;
  logic              commit;

  assign hi       = addr_i[15:8];
  assign rom_en_o = ~romctl_q[0];
  assign bank_o   = bank_q;

  assign is_reg  = (addr_i == REG_BANK_LO) || (addr_i == REG_BANK_HI) ||
                   (addr_i == REG_ROMCTL);
  assign is_io   = (hi == IO_PAGE);
  assign in_win  = (hi >= ROM_BASE) && (hi <= ROM_TOP_HI);
  assign bank_ok = (bank_q < 16'(NUM_CH));

  // Priority decode: registers, vector page, IO page, ROM window, RAM.
  always_comb begin
    sel_ram = 1'b0;
    sel_rom = 1'b0;
    io_map  = 1'b0;
    src_d   = SRC_RAM;
    if (is_reg) begin
      src_d = SRC_REG;
    end else if (hi == VEC_PAGE) begin
      sel_rom = 1'b1;
      src_d   = SRC_ROM;
    end else if (is_io) begin
      io_map = bank_ok;
      src_d  = bank_ok ? SRC_CH : SRC_NONE;
    end else if (in_win && rom_en_o) begin
      sel_rom = 1'b1;
      src_d   = SRC_ROM;
    end else begin
      sel_ram = 1'b1;
      src_d   = SRC_RAM;
    end
  end

  assign ram_cs_o   = sel_ram;
  assign rom_cs_o   = sel_rom;
  assign reg_addr_o = addr_i[7:0];

  always_comb begin
    ch_cs_o  = '0;
    wait_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bank_q[3:0] == 4'(k)) begin
        ch_cs_o[k] = io_map;
        wait_sel   = ch_wait_i[k*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    regval_d = OPEN_BUS;
    case (addr_i[1:0])
      2'd0:    regval_d = bank_q[7:0];
      2'd1:    regval_d = bank_q[15:8];
      2'd2:    regval_d = romctl_q;
      default: regval_d = OPEN_BUS;
    endcase
  end

  io_wait_ctrl #(
    .WAIT_W   (WAIT_W)
  ) u_wait (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (io_map),
    .wait_i   (wait_sel),
    .rdy_o    (rdy_o),
    .commit_o (commit)
  );

  assign ch_rd_o = commit & ~we_i;
  assign ch_wr_o = commit &  we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q   <= 16'h0000;
      romctl_q <= 8'h00;
      src_q    <= SRC_NONE;
      chsel_q  <= 4'd0;
      regval_q <= OPEN_BUS;
    end else begin
      if (rdy_o && we_i && is_reg) begin
        case (addr_i[1:0])
          2'd0:    bank_q[7:0]  <= data_i;
          2'd1:    bank_q[15:8] <= data_i;
          2'd2:    romctl_q     <= data_i;
          default: ;
        endcase
      end
      if (rdy_o) begin
        src_q    <= src_d;
        regval_q <= regval_d;
        chsel_q  <= bank_q[3:0];
      end
    end
  end

  always_comb begin
    ch_rd_data = OPEN_BUS;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chsel_q == 4'(k)) ch_rd_data = ch_data_i[8*k +: 8];
    end
  end

  always_comb begin
    case (src_q)
      SRC_RAM:  data_o = ram_data_i;
      SRC_ROM:  data_o = rom_data_i;
      SRC_REG:  data_o = regval_q;
      SRC_CH:   data_o = ch_rd_data;
      default:  data_o = OPEN_BUS;
    endcase
  end

endmodule
